// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control unit: widths,
// opcode field layout, opcode values and the buffered fetch entry type.
package fetch_unit_pkg;

  localparam int INSTR_W = 19;
  localparam int ADDR_W  = 16;
  localparam int OPC_MSB = 18;
  localparam int OPC_LSB = 14;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_LOAD   = 5'd2,
    OP_STORE  = 5'd3,
    OP_BRANCH = 5'd4,
    OP_JUMP   = 5'd5
  } opcode_e;

  // ADD with all operand fields zero has no architectural effect.
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_ADD, {(INSTR_W-OPC_W){1'b0}}};

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] i);
    return opcode_e'(i[OPC_MSB:OPC_LSB]);
  endfunction

  function automatic logic is_nop(input logic [INSTR_W-1:0] i);
    return (i == NOP_INSTR);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: memory request/response, decode handshake and
// redirect input. master = fetch unit, slave = environment.
interface fetch_unit_if
  import fetch_unit_pkg::*;
();

  logic               fetch_en;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;

  modport master (
    input  fetch_en,
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
    output fetch_en,
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    output redirect_valid,
    output redirect_target
  );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Small synchronous FIFO of {pc, instr} entries between memory and decode.
// flush empties the buffer and wins over a push in the same cycle.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  fetch_entry_t      push_entry,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output fetch_entry_t      head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && !flush;
    do_pop   = pop && (count_q != '0);

    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // The issue rule upstream never lets a push land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency word reads and
// queues returned instructions with their PC for decode; squashes on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("fetch_unit: DEPTH must be at least 2");
  end

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]  buf_count;
  fetch_entry_t      buf_head;
  fetch_entry_t      push_entry;
  logic              pop, push, issue, has_room;
  logic [OCC_W-1:0]  occupancy;

  // Issue only when the slot is guaranteed free on return; the pop term lets
  // a full pipe keep streaming one instruction per cycle.
  always_comb begin
    pop        = (buf_count != '0) && bus.instr_ready;
    push       = inflight_q && !bus.redirect_valid;
    push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};
    occupancy  = OCC_W'(buf_count) + OCC_W'(inflight_q);
    has_room   = (occupancy < OCC_W'(DEPTH)) ||
                 ((occupancy == OCC_W'(DEPTH)) && pop);
    issue      = rst_n && bus.fetch_en && !bus.redirect_valid && has_room;

    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;

    if (bus.redirect_valid) begin
      pc_d = bus.redirect_target;
    end else if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (buf_count),
    .head       (buf_head)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (buf_count != '0);
  assign bus.instr       = buf_head.instr;
  assign bus.instr_pc    = buf_head.pc;

endmodule
